// File: rtl/comm_master_seq.sv
// Command initiator for the UART command link: sends a cmd/data frame, waits for a one-byte reply, checks it.
// Optional resend on wrong byte or timeout is enabled by defining COMM_RETRY_EN.
module comm_master_seq #(
    parameter int          TMO_W     = 16,
    parameter int          MAX_RETRY = 2,
    parameter logic [7:0]  ACK_VAL   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [7:0]  cmd_in,
    input  logic [15:0] data_in,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        busy,
    output logic        frm_snt,
    output logic        done,
    output logic [7:0]  resp,
    output logic        ack_ok,
    output logic        nak_err,
    output logic        tmo_err
);

    localparam logic [7:0] CMD_REQ_BATT = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        TX_CMD,
        TX_DHI,
        TX_DLO,
        WAIT_RESP,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic              phase_reg, phase_next;
    logic [7:0]        cmd_q_reg, cmd_q_next;
    logic [15:0]       data_q_reg, data_q_next;
    logic [7:0]        tx_data_reg, tx_data_next;
    logic              trmt_reg, trmt_next;
    logic              clr_rx_rdy_reg, clr_rx_rdy_next;
    logic              busy_reg, busy_next;
    logic              frm_snt_reg, frm_snt_next;
    logic              done_reg, done_next;
    logic [7:0]        resp_reg, resp_next;
    logic              ack_ok_reg, ack_ok_next;
    logic              nak_err_reg, nak_err_next;
    logic              tmo_err_reg, tmo_err_next;
    logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic              attempt_fail;
    logic              fail_is_nak;
    logic              retry_left;

`ifdef COMM_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTY_W-1:0]  retry_cnt_reg, retry_cnt_next;

    assign retry_left = (int'(retry_cnt_reg) < MAX_RETRY);
`else
    assign retry_left = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            phase_reg      <= 1'b0;
            cmd_q_reg      <= 8'h00;
            data_q_reg     <= 16'h0000;
            tx_data_reg    <= 8'h00;
            trmt_reg       <= 1'b0;
            clr_rx_rdy_reg <= 1'b0;
            busy_reg       <= 1'b0;
            frm_snt_reg    <= 1'b0;
            done_reg       <= 1'b0;
            resp_reg       <= 8'h00;
            ack_ok_reg     <= 1'b0;
            nak_err_reg    <= 1'b0;
            tmo_err_reg    <= 1'b0;
            tmo_cnt_reg    <= '0;
`ifdef COMM_RETRY_EN
            retry_cnt_reg  <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            cmd_q_reg      <= cmd_q_next;
            data_q_reg     <= data_q_next;
            tx_data_reg    <= tx_data_next;
            trmt_reg       <= trmt_next;
            clr_rx_rdy_reg <= clr_rx_rdy_next;
            busy_reg       <= busy_next;
            frm_snt_reg    <= frm_snt_next;
            done_reg       <= done_next;
            resp_reg       <= resp_next;
            ack_ok_reg     <= ack_ok_next;
            nak_err_reg    <= nak_err_next;
            tmo_err_reg    <= tmo_err_next;
            tmo_cnt_reg    <= tmo_cnt_next;
`ifdef COMM_RETRY_EN
            retry_cnt_reg  <= retry_cnt_next;
`endif
        end
    end

    // phase_reg marks the second half of TX_CMD (trmt already issued) and of DONE (done already pulsed)
    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        cmd_q_next      = cmd_q_reg;
        data_q_next     = data_q_reg;
        tx_data_next    = tx_data_reg;
        trmt_next       = 1'b0;
        clr_rx_rdy_next = 1'b0;
        frm_snt_next    = 1'b0;
        done_next       = 1'b0;
        resp_next       = resp_reg;
        ack_ok_next     = ack_ok_reg;
        nak_err_next    = nak_err_reg;
        tmo_err_next    = tmo_err_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        attempt_fail    = 1'b0;
        fail_is_nak     = 1'b0;
`ifdef COMM_RETRY_EN
        retry_cnt_next  = retry_cnt_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (go) begin
                    cmd_q_next      = cmd_in;
                    data_q_next     = data_in;
                    ack_ok_next     = 1'b0;
                    nak_err_next    = 1'b0;
                    tmo_err_next    = 1'b0;
                    clr_rx_rdy_next = 1'b1;
                    phase_next      = 1'b0;
                    state_next      = TX_CMD;
`ifdef COMM_RETRY_EN
                    retry_cnt_next  = '0;
`endif
                end
            end

            TX_CMD: begin
                if (!phase_reg) begin
                    trmt_next    = 1'b1;
                    tx_data_next = cmd_q_reg;
                    phase_next   = 1'b1;
                end else if (tx_done) begin
                    trmt_next    = 1'b1;
                    tx_data_next = data_q_reg[15:8];
                    state_next   = TX_DHI;
                end
            end

            TX_DHI: begin
                if (tx_done) begin
                    trmt_next    = 1'b1;
                    tx_data_next = data_q_reg[7:0];
                    state_next   = TX_DLO;
                end
            end

            TX_DLO: begin
                if (tx_done) begin
                    frm_snt_next = 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = WAIT_RESP;
                end
            end

            WAIT_RESP: begin
                // a received byte takes priority over a simultaneous terminal count
                if (rx_rdy) begin
                    resp_next       = rx_data;
                    clr_rx_rdy_next = 1'b1;
                    if ((cmd_q_reg == CMD_REQ_BATT) || (rx_data == ACK_VAL)) begin
                        ack_ok_next = 1'b1;
                        phase_next  = 1'b0;
                        state_next  = DONE;
                    end else begin
                        attempt_fail = 1'b1;
                        fail_is_nak  = 1'b1;
                    end
                end else if (tmo_cnt_reg == {TMO_W{1'b1}}) begin
                    attempt_fail = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end

                if (attempt_fail) begin
                    phase_next = 1'b0;
                    if (retry_left) begin
`ifdef COMM_RETRY_EN
                        retry_cnt_next = retry_cnt_reg + 1'b1;
`endif
                        state_next = TX_CMD;
                    end else begin
                        nak_err_next = fail_is_nak;
                        tmo_err_next = !fail_is_nak;
                        state_next   = DONE;
                    end
                end
            end

            DONE: begin
                if (!phase_reg) begin
                    done_next  = 1'b1;
                    phase_next = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign tx_data    = tx_data_reg;
    assign trmt       = trmt_reg;
    assign clr_rx_rdy = clr_rx_rdy_reg;
    assign busy       = busy_reg;
    assign frm_snt    = frm_snt_reg;
    assign done       = done_reg;
    assign resp       = resp_reg;
    assign ack_ok     = ack_ok_reg;
    assign nak_err    = nak_err_reg;
    assign tmo_err    = tmo_err_reg;

endmodule

// File: doc/comm_master_seq.md
# comm_master_seq

Command initiator for the remote side of the UART command link. It serializes a one-byte command and a 16-bit data word into a three-byte frame, waits for the single-byte response from the copter's command configuration unit, and checks that response. It sits between the host or test driver and the byte-level UART transmitter and receiver, and it provides timeout and optional retry handling.

## Interface
- TMO_W, 16: width of the response timeout counter; timeout occurs after 2^TMO_W−1 cycles in WAIT_RESP.
- MAX_RETRY, 2: number of resends allowed after the first attempt (only when COMM_RETRY_EN is defined).
- ACK_VAL, 8'hA5: expected acknowledge byte.
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  start request; sampled only in IDLE.
- cmd_in  input  8  command byte; 8'h01 = REQ_BATT.
- data_in  input  16  command data.
- tx_data  output  8  byte to UART transmitter.
- trmt  output  1  one-cycle pulse that starts a byte transmit.
- tx_done  input  1  one-cycle pulse when the UART finishes a byte.
- rx_rdy  input  1  level signal: a received byte is valid.
- rx_data  input  8  received byte.
- clr_rx_rdy  output  1  one-cycle pulse that consumes or discards a received byte.
- busy  output  1  high in every state except IDLE.
- frm_snt  output  1  one-cycle pulse after the third byte's tx_done.
- done  output  1  one-cycle pulse at transaction end.
- resp  output  8  last captured response byte.
- ack_ok  output  1  response accepted; valid from done until the next go.
- nak_err  output  1  wrong response byte on the final attempt.
- tmo_err  output  1  no response on the final attempt.

## Operation
- States: IDLE, TX_CMD, TX_DHI, TX_DLO, WAIT_RESP, DONE.
- IDLE, go=1:
  - latch cmd_in/data_in into cmd_q/data_q;
  - clear ack_ok, nak_err, tmo_err and the retry counter;
  - pulse clr_rx_rdy to discard any stale byte;
  - move to TX_CMD.
- TX_CMD, TX_DHI, TX_DLO:
  - On entry, drive tx_data with cmd_q, data_q[15:8] or data_q[7:0] respectively, and pulse trmt once.
  - Hold tx_data stable until tx_done, then advance.
  - tx_done in TX_DLO: pulse frm_snt, clear the timeout counter, move to WAIT_RESP.
- WAIT_RESP:
  - The timeout counter increments each cycle.
  - If rx_rdy=1: capture rx_data into resp, pulse clr_rx_rdy, then evaluate.
    - cmd_q==8'h01: any byte is accepted (battery level).
    - Any other command: the byte is accepted only if it equals ACK_VAL.
  - If the counter reaches all-ones with rx_rdy=0, the attempt fails by timeout.
  - If rx_rdy and terminal count occur in the same cycle, rx_rdy wins.
- Failed attempt (wrong byte or timeout):
  - If retries remain, increment the retry counter and return to TX_CMD with the same cmd_q/data_q.
  - Otherwise set nak_err or tmo_err (exactly one) and go to DONE.
- Accepted response: set ack_ok and go to DONE.
- DONE: pulse done and return to IDLE next cycle. resp and the flags hold until the next go.
- Ignored inputs:
  - go while busy is ignored.
  - rx_rdy during TX_* states is ignored; the byte is not consumed.
  - tx_done outside TX_* states is ignored.

## Timing
- Reset values:
  - state=IDLE;
  - tx_data=8'h00, resp=8'h00;
  - trmt, clr_rx_rdy, frm_snt, done = 0;
  - busy, ack_ok, nak_err, tmo_err = 0.
- Reset asserted mid-transaction returns to IDLE on the next clk edge; no partial frame resumes.
- go sampled at edge N: busy=1 and clr_rx_rdy=1 at N+1; trmt=1 with tx_data=cmd_q at N+2.
- tx_done at edge M in TX_CMD/TX_DHI: the next trmt occurs at M+1.
- tx_done at edge M in TX_DLO: frm_snt at M+1.
- rx_rdy sampled at edge R in WAIT_RESP:
  - resp valid and clr_rx_rdy=1 at R+1;
  - done at R+2;
  - busy=0 at R+3.
- Timeout: 2^TMO_W−1 cycles after frm_snt without rx_rdy.
- Counters saturate and never wrap.
- All outputs are registered.

## Configuration
- COMM_RETRY_EN defined: resend up to MAX_RETRY times on a wrong byte or timeout. A transaction sends at most MAX_RETRY+1 frames.
- Not defined: single attempt. Any failure goes straight to DONE with an error flag set; the retry counter is not synthesized.

## Test plan
- cmd_in=8'h02, data_in=16'h0006; rx_data=8'hA5 returned after frm_snt -> bytes sent 02, 00, 06 in order; done with ack_ok=1, resp=8'hA5.
- cmd_in=8'h01, data_in=16'h0000; rx_data=8'h21 -> ack_ok=1, resp=8'h21, nak_err=0.
- cmd_in=8'h05, data_in=16'h0008; first response 8'h5A, second 8'hA5, COMM_RETRY_EN on -> two frames sent; ack_ok=1.
- TMO_W=4, no response, COMM_RETRY_EN on, MAX_RETRY=2 -> 3 frm_snt pulses; done with tmo_err=1, ack_ok=0.
- Same stimulus with COMM_RETRY_EN off -> 1 frm_snt pulse, then tmo_err=1.
- go re-pulsed during TX_DHI, and rst asserted during WAIT_RESP -> second go ignored; after reset state=IDLE, busy=0, all flags 0.
